// File: rtl/tick_timer_pkg.sv
// Shared types for the tick timer: FSM state and run-mode encodings.
package tick_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } tmr_state_t;

   typedef enum logic {
      ONE_SHOT = 1'b0,
      PERIODIC = 1'b1
   } tmr_mode_t;

   localparam int TMR_WIDTH_DFLT = 8;

endpackage

// File: rtl/tick_timer_if.sv
// Control/status bundle between the local controller (master) and the tick timer (slave).
interface tick_timer_if #(
   parameter int WIDTH = 8
);
   logic             tick_in;
   logic             start;
   logic             stop;
   logic             mode;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] compare;
   logic             irq_clr;
   logic [WIDTH-1:0] count;
   logic             pwm_out;
   logic             irq;
   logic             busy;

   modport master (
      output tick_in, start, stop, mode, period, compare, irq_clr,
      input  count, pwm_out, irq, busy
   );

   modport slave (
      input  tick_in, start, stop, mode, period, compare, irq_clr,
      output count, pwm_out, irq, busy
   );
endinterface

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for a level tick; a tick held high for many cycles yields one pulse.
module tick_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   output logic rise_o
);
   logic level_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_i;
      end
   end

   assign rise_o = level_i & ~level_q;
endmodule

// File: rtl/tick_timer.sv
// Programmable tick timer / PWM stage with one-shot and periodic modes and sticky wrap irq.
//  state | meaning
//  IDLE  | stopped, count forced to 0
//  RUN   | counting tick edges, busy=1, pwm active
//  DONE  | one-shot expired, count holds period
module tick_timer
   import tick_timer_pkg::*;
#(
   parameter int WIDTH = TMR_WIDTH_DFLT
) (
   input logic        clk,
   input logic        reset,
   tick_timer_if.slave bus
);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   logic [1:0]       state_q,   state_d;
   logic [WIDTH-1:0] count_q,   count_d;
   logic [WIDTH-1:0] period_q,  period_d;
   logic [WIDTH-1:0] compare_q, compare_d;
   tmr_mode_t        mode_q,    mode_d;
   logic             irq_q,     irq_d;
   logic             tick_rise;
   logic             busy_c;
   logic             pwm_c;

   tick_edge_detect u_edge (
      .clk     (clk),
      .reset   (reset),
      .level_i (bus.tick_in),
      .rise_o  (tick_rise)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         period_q  <= '0;
         compare_q <= '0;
         mode_q    <= ONE_SHOT;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         period_q  <= period_d;
         compare_q <= compare_d;
         mode_q    <= mode_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      period_d  = period_q;
      compare_d = compare_q;
      mode_d    = mode_q;
      // A wrap later in this block overrides the clear, so set wins over irq_clr.
      irq_d     = irq_q & ~bus.irq_clr;

      case (state_q)
         S_IDLE: begin
            count_d = '0;
            if (bus.start && !bus.stop) begin
               state_d   = S_RUN;
               period_d  = bus.period;
               compare_d = bus.compare;
               mode_d    = tmr_mode_t'(bus.mode);
            end
         end
         S_RUN: begin
            if (bus.stop) begin
               state_d = S_IDLE;
               count_d = '0;
            end else if (tick_rise) begin
               if (count_q == period_q) begin
                  irq_d = 1'b1;
                  if (mode_q == PERIODIC) begin
                     count_d   = '0;
                     period_d  = bus.period;
                     compare_d = bus.compare;
                     mode_d    = tmr_mode_t'(bus.mode);
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end
         end
         S_DONE: begin
            if (bus.stop) begin
               state_d = S_IDLE;
               count_d = '0;
            end else if (bus.start) begin
               state_d   = S_RUN;
               count_d   = '0;
               period_d  = bus.period;
               compare_d = bus.compare;
               mode_d    = tmr_mode_t'(bus.mode);
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
         end
      endcase

      busy_c = (state_q == S_RUN);
      pwm_c  = busy_c && (count_q < compare_q);
   end

   assign bus.count   = count_q;
   assign bus.irq     = irq_q;
   assign bus.busy    = busy_c;
   assign bus.pwm_out = pwm_c;
endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios plus random traffic against a behavioural model.
module tb_tick_timer;
   import tick_timer_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   tick_timer_if #(.WIDTH(W)) bus ();

   tick_timer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase 0=stopped, 1=running, 2=expired.
   int m_ph, m_cnt, m_per, m_cmp, m_mode, m_irq, m_tprev;

   function automatic void m_reset();
      m_ph = 0; m_cnt = 0; m_per = 0; m_cmp = 0; m_mode = 0; m_irq = 0; m_tprev = 0;
   endfunction

   function automatic void m_latch();
      m_per  = int'(bus.period);
      m_cmp  = int'(bus.compare);
      m_mode = int'(bus.mode);
      m_cnt  = 0;
   endfunction

   function automatic void m_clock();
      int rise;
      int nirq;
      if (!reset) begin
         m_reset();
         return;
      end
      rise    = (bus.tick_in && m_tprev == 0) ? 1 : 0;
      m_tprev = bus.tick_in ? 1 : 0;
      nirq    = (m_irq == 1 && !bus.irq_clr) ? 1 : 0;
      if (bus.stop) begin
         m_ph  = 0;
         m_cnt = 0;
      end else if (bus.start && m_ph != 1) begin
         m_ph = 1;
         m_latch();
      end else if (m_ph == 1 && rise == 1) begin
         if (m_cnt == m_per) begin
            nirq = 1;
            if (m_mode == 1) m_latch();
            else m_ph = 2;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
      m_irq = nirq;
   endfunction

   function automatic logic [W+2:0] exp_vec();
      logic p;
      p = (m_ph == 1) && (m_cnt < m_cmp);
      return {W'(m_cnt), p, (m_irq == 1), (m_ph == 1)};
   endfunction

   function automatic logic [W+2:0] obs_vec();
      return {bus.count, bus.pwm_out, bus.irq, bus.busy};
   endfunction

   task automatic cyc();
      @(posedge clk);
      m_clock();
      #1;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.irq_clr = 1'b0;
   endtask

   task automatic pulse(input int hi, input int lo);
      bus.tick_in = 1'b1;
      repeat (hi) cyc();
      bus.tick_in = 1'b0;
      repeat (lo) cyc();
   endtask

   task automatic do_start(input int per, input int cmp, input int md);
      bus.period  = W'(per);
      bus.compare = W'(cmp);
      bus.mode    = md[0];
      bus.start   = 1'b1;
      cyc();
   endtask

   task automatic test_reset();
      total++;
      if (obs_vec() !== '0) begin
         bad++;
         $display("FAIL reset_init got %h want 0", obs_vec());
      end
      do_start(0, 30, 0);
      pulse(1, 1);
      do_start(20, 30, 0);
      repeat (5) pulse(1, 1);
      total++;
      if (obs_vec() !== {8'd5, 1'b1, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL reset_pre got %h want %h", obs_vec(), {8'd5, 1'b1, 1'b1, 1'b1});
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (obs_vec() !== '0) begin
         bad++;
         $display("FAIL reset_async got %h want 0", obs_vec());
      end
      m_reset();
      repeat (2) cyc();
      reset = 1'b1;
      cyc();
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL reset_release got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_one_shot();
      int ec[4] = '{1, 2, 3, 3};
      int eb[4] = '{1, 1, 1, 0};
      int ei[4] = '{0, 0, 0, 1};
      int ep[4] = '{1, 0, 0, 0};
      do_start(3, 2, 0);
      total++;
      if (obs_vec() !== {8'd0, 1'b1, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL one_shot_start got %h want %h", obs_vec(), {8'd0, 1'b1, 1'b0, 1'b1});
      end
      for (int i = 0; i < 4; i++) begin
         pulse(1, 1);
         total++;
         if (obs_vec() !== {W'(ec[i]), ep[i][0], ei[i][0], eb[i][0]} || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL one_shot edge %0d got %h want %h", i + 1, obs_vec(),
                     {W'(ec[i]), ep[i][0], ei[i][0], eb[i][0]});
         end
      end
      bus.stop = 1'b1;
      bus.irq_clr = 1'b1;
      cyc();
   endtask

   task automatic test_periodic_shadow();
      do_start(2, 1, 1);
      bus.period = 8'd4;
      pulse(1, 1);
      pulse(1, 1);
      total++;
      if (bus.count !== 8'd2 || bus.irq !== 1'b0) begin
         bad++;
         $display("FAIL periodic_pre_wrap1 got cnt=%0d irq=%0b want cnt=2 irq=0", bus.count, bus.irq);
      end
      pulse(1, 1);
      total++;
      if (bus.count !== 8'd0 || bus.irq !== 1'b1 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL periodic_wrap1 got cnt=%0d irq=%0b busy=%0b want 0 1 1", bus.count, bus.irq, bus.busy);
      end
      bus.irq_clr = 1'b1;
      cyc();
      total++;
      if (bus.irq !== 1'b0) begin
         bad++;
         $display("FAIL periodic_clr got irq=%0b want 0", bus.irq);
      end
      repeat (4) pulse(1, 1);
      total++;
      if (bus.count !== 8'd4 || bus.irq !== 1'b0) begin
         bad++;
         $display("FAIL periodic_pre_wrap2 got cnt=%0d irq=%0b want cnt=4 irq=0", bus.count, bus.irq);
      end
      pulse(1, 1);
      total++;
      if (obs_vec() !== {8'd0, 1'b1, 1'b1, 1'b1} || obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL periodic_wrap2 got %h want %h", obs_vec(), {8'd0, 1'b1, 1'b1, 1'b1});
      end
      bus.stop = 1'b1;
      bus.irq_clr = 1'b1;
      cyc();
   endtask

   task automatic test_edge_detect();
      bus.tick_in = 1'b1;
      do_start(50, 0, 0);
      total++;
      if (bus.count !== 8'd0 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL edge_coincident got cnt=%0d busy=%0b want 0 1", bus.count, bus.busy);
      end
      pulse(0, 2);
      pulse(10, 1);
      total++;
      if (obs_vec() !== {8'd1, 1'b0, 1'b0, 1'b1} || obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL edge_held got %h want %h", obs_vec(), {8'd1, 1'b0, 1'b0, 1'b1});
      end
      bus.stop = 1'b1;
      cyc();
   endtask

   task automatic test_collisions();
      bus.period = 8'd3;
      bus.start  = 1'b1;
      bus.stop   = 1'b1;
      cyc();
      total++;
      if (bus.busy !== 1'b0 || bus.count !== 8'd0) begin
         bad++;
         $display("FAIL start_stop_idle got busy=%0b cnt=%0d want 0 0", bus.busy, bus.count);
      end
      do_start(5, 9, 0);
      repeat (2) pulse(1, 1);
      bus.period = 8'd0;
      bus.start  = 1'b1;
      cyc();
      total++;
      if (bus.count !== 8'd2 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL start_in_run got cnt=%0d busy=%0b want 2 1", bus.count, bus.busy);
      end
      bus.stop = 1'b1;
      cyc();
      do_start(1, 1, 1);
      pulse(1, 1);
      bus.tick_in = 1'b1;
      bus.irq_clr = 1'b1;
      cyc();
      bus.tick_in = 1'b0;
      total++;
      if (bus.irq !== 1'b1 || bus.count !== 8'd0) begin
         bad++;
         $display("FAIL clr_on_wrap got irq=%0b cnt=%0d want 1 0", bus.irq, bus.count);
      end
      pulse(1, 1);
      bus.stop = 1'b1;
      cyc();
      total++;
      if (obs_vec() !== {8'd0, 1'b0, 1'b1, 1'b0} || obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL stop_in_run got %h want %h", obs_vec(), {8'd0, 1'b0, 1'b1, 1'b0});
      end
      bus.irq_clr = 1'b1;
      cyc();
   endtask

   task automatic test_extremes();
      int pwm_bad = 0;
      do_start(0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         bus.irq_clr = 1'b1;
         cyc();
         pulse(1, 1);
         total++;
         if (obs_vec() !== {8'd0, 1'b0, 1'b1, 1'b1} || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL period0 wrap %0d got %h want %h", i, obs_vec(), {8'd0, 1'b0, 1'b1, 1'b1});
         end
      end
      bus.stop = 1'b1;
      bus.irq_clr = 1'b1;
      cyc();
      do_start(255, 255, 0);
      for (int i = 1; i <= 255; i++) begin
         pulse(1, 1);
         if (bus.pwm_out !== (i < 255) || bus.count !== W'(i)) pwm_bad++;
      end
      total++;
      if (pwm_bad != 0 || obs_vec() !== {8'd255, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL max_period pwm_errs=%0d got %h want %h", pwm_bad, obs_vec(), {8'd255, 1'b0, 1'b0, 1'b1});
      end
      pulse(1, 1);
      total++;
      if (obs_vec() !== {8'd255, 1'b0, 1'b1, 1'b0} || obs_vec() !== exp_vec()) begin
         bad++;
         $display("FAIL max_period_done got %h want %h", obs_vec(), {8'd255, 1'b0, 1'b1, 1'b0});
      end
      bus.stop = 1'b1;
      bus.irq_clr = 1'b1;
      cyc();
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 600; i++) begin
         bus.tick_in = 1'($urandom_range(0, 1));
         bus.start   = ($urandom_range(0, 11) == 0);
         bus.stop    = ($urandom_range(0, 39) == 0);
         bus.irq_clr = ($urandom_range(0, 9) == 0);
         bus.mode    = 1'($urandom_range(0, 1));
         bus.period  = W'($urandom_range(0, 5));
         bus.compare = W'($urandom_range(0, 7));
         cyc();
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++;
            errs++;
            if (errs <= 5)
               $display("FAIL random cyc %0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      reset       = 1'b0;
      bus.tick_in = 1'b0;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.mode    = 1'b0;
      bus.period  = '0;
      bus.compare = '0;
      bus.irq_clr = 1'b0;
      m_reset();
      repeat (3) cyc();
      reset = 1'b1;
      cyc();
      test_reset();
      test_one_shot();
      test_periodic_shadow();
      test_edge_detect();
      test_collisions();
      test_extremes();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
